sys_bus_responder: RTL

SYS_BUS_RESPONDER -- requirements
Module: sys_bus_responder

---
 rtl/sys_bus_responder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sys_bus_responder.sv
// CPU-side register block: ID/scratch regs, optional timer (SYS_RESP_TIMER_EN), 4-deep push FIFO.
// Latency: reads are combinational; writes, timer updates and FIFO push/pop land on the next clk edge.
// Backpressure: FIFO output is valid/ready; a push while full with no pop is dropped and sets overflow.
module sys_bus_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sys_r_addr,
    input  logic [31:0] sys_w_addr,
    input  logic [31:0] sys_w_line,
    input  logic        sys_read,
    input  logic        sys_write,
    output logic [31:0] sys_r_line,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        irq
);

    typedef enum logic [2:0] {
        R_ID, R_SCRATCH, R_TIMER, R_TCTRL, R_TCMP, R_FDATA, R_FSTAT, R_NONE
    } reg_e;

    // Only the low 256-byte page decodes; the byte lane bits are don't-care.
    function automatic reg_e decode(input logic [31:0] addr);
        reg_e sel;
        sel = R_NONE;
        if (addr[31:8] == 24'd0) begin
            casez (addr[7:0])
                8'b000000??: sel = R_ID;
                8'b000001??: sel = R_SCRATCH;
                8'b000010??: sel = R_TIMER;
                8'b000011??: sel = R_TCTRL;
                8'b000100??: sel = R_TCMP;
                8'b000101??: sel = R_FDATA;
                8'b000110??: sel = R_FSTAT;
                default:     sel = R_NONE;
            endcase
        end
        return sel;
    endfunction

    reg_e r_sel;
    reg_e w_sel;

    logic [31:0] scratch_q, scratch_d;
    logic [31:0] timer_q,   timer_d;
    logic [31:0] tcmp_q,    tcmp_d;
    logic [3:0]  tctrl_q,   tctrl_d;   // {irq_en, flag, autoreload, enable}
    logic        irq_q,     irq_d;

    logic [31:0] mem_q [4];
    logic [31:0] mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q,  count_d;
    logic        ovf_q,    ovf_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic accept;

    always_comb begin
        r_sel = sys_read  ? decode(sys_r_addr) : R_NONE;
        w_sel = sys_write ? decode(sys_w_addr) : R_NONE;
    end

    always_comb begin
        sys_r_line = 32'd0;
        case (r_sel)
            R_ID:      sys_r_line = 32'h4350_5533;
            R_SCRATCH: sys_r_line = scratch_q;
            R_TIMER:   sys_r_line = timer_q;
            R_TCTRL:   sys_r_line = {28'd0, tctrl_q};
            R_TCMP:    sys_r_line = tcmp_q;
            R_FSTAT:   sys_r_line = {26'd0, ovf_q, fifo_empty, fifo_full, count_q};
            default:   sys_r_line = 32'd0;
        endcase
    end

    always_comb begin
        scratch_d = scratch_q;
        if (w_sel == R_SCRATCH) begin
            scratch_d = sys_w_line;
        end
    end

`ifdef SYS_RESP_TIMER_EN
    logic match;

    always_comb begin
        timer_d = timer_q;
        tcmp_d  = tcmp_q;
        tctrl_d = tctrl_q;
        irq_d   = tctrl_q[2] & tctrl_q[3];
        match   = tctrl_q[0] && (timer_q == tcmp_q);

        if (tctrl_q[0]) begin
            timer_d = (match && tctrl_q[1]) ? 32'd0 : timer_q + 32'd1;
        end
        // CPU write beats both increment and reload.
        if (w_sel == R_TIMER) begin
            timer_d = sys_w_line;
        end
        if (w_sel == R_TCMP) begin
            tcmp_d = sys_w_line;
        end
        if (w_sel == R_TCTRL) begin
            tctrl_d[0] = sys_w_line[0];
            tctrl_d[1] = sys_w_line[1];
            tctrl_d[3] = sys_w_line[3];
            if (sys_w_line[2]) begin
                tctrl_d[2] = 1'b0;
            end
        end
        // Hardware set is applied last so it wins over a same-cycle clear.
        if (match) begin
            tctrl_d[2] = 1'b1;
        end
    end
`else
    always_comb begin
        timer_d = 32'd0;
        tcmp_d  = 32'd0;
        tctrl_d = 4'd0;
        irq_d   = 1'b0;
    end
`endif

    always_comb begin
        fifo_full  = (count_q == 3'd4);
        fifo_empty = (count_q == 3'd0);
        push       = (w_sel == R_FDATA);
        pop        = !fifo_empty && out_ready;
        accept     = push && (!fifo_full || pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;

        if (accept) begin
            mem_d[wr_ptr_q] = sys_w_line;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        count_d = count_q + {2'd0, accept} - {2'd0, pop};

        if ((w_sel == R_FSTAT) && sys_w_line[5]) begin
            ovf_d = 1'b0;
        end
        if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scratch_q <= 32'd0;
            timer_q   <= 32'd0;
            tcmp_q    <= 32'd0;
            tctrl_q   <= 4'd0;
            irq_q     <= 1'b0;
            mem_q     <= '{default: 32'd0};
            wr_ptr_q  <= 2'd0;
            rd_ptr_q  <= 2'd0;
            count_q   <= 3'd0;
            ovf_q     <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            timer_q   <= timer_d;
            tcmp_q    <= tcmp_d;
            tctrl_q   <= tctrl_d;
            irq_q     <= irq_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = mem_q[rd_ptr_q];
    assign irq       = irq_q;

endmodule
